// File: rtl/btn_press_ctrl_if.sv
// Button controller handshake bundle: button level and enable in, press/step events out.
interface btn_press_ctrl_if;
    logic btn_in;
    logic en;
    logic press_pulse;
    logic release_pulse;
    logic step_pulse;
    logic long_hold;

    modport master (
        output btn_in,
        output en,
        input  press_pulse,
        input  release_pulse,
        input  step_pulse,
        input  long_hold
    );

    modport slave (
        input  btn_in,
        input  en,
        output press_pulse,
        output release_pulse,
        output step_pulse,
        output long_hold
    );
endinterface

// File: rtl/btn_press_ctrl.sv
// Turns a debounced button level into press/release pulses and auto-repeating step pulses.
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | waiting for an armed 0->1 edge on btn_in
// PRESSED | button held, counting towards the hold threshold
// REPEAT  | long hold, step pulse every REPEAT_CYCLES
module btn_press_ctrl #(
    parameter int CNT_W         = 26,
    parameter int HOLD_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000
) (
    input  logic          cclk,
    input  logic          clr,
    btn_press_ctrl_if.slave bus
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] PRESSED = 2'd1;
    localparam logic [1:0] REPEAT  = 2'd2;

    localparam logic [CNT_W-1:0] HOLD_TC   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_TC = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             btn_q;
    logic             press_r;
    logic             release_r;
    logic             step_r;
    logic             long_r;

    // btn_q resets high so a button held through reset or disable is not taken as a press.
    always_ff @(posedge cclk or posedge clr) begin
        if (clr) begin
            state     <= IDLE;
            cnt       <= '0;
            btn_q     <= 1'b1;
            press_r   <= 1'b0;
            release_r <= 1'b0;
            step_r    <= 1'b0;
            long_r    <= 1'b0;
        end else begin
            btn_q     <= bus.btn_in;
            press_r   <= 1'b0;
            release_r <= 1'b0;
            step_r    <= 1'b0;
            if (!bus.en) begin
                state  <= IDLE;
                cnt    <= '0;
                long_r <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.btn_in && !btn_q) begin
                            state   <= PRESSED;
                            cnt     <= '0;
                            press_r <= 1'b1;
                            step_r  <= 1'b1;
                        end
                    end
                    PRESSED: begin
                        if (!bus.btn_in) begin
                            state     <= IDLE;
                            release_r <= 1'b1;
                            cnt       <= '0;
                        end else if (cnt == HOLD_TC) begin
                            state  <= REPEAT;
                            step_r <= 1'b1;
                            long_r <= 1'b1;
                            cnt    <= '0;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    REPEAT: begin
                        // release wins over a coincident terminal count
                        if (!bus.btn_in) begin
                            state     <= IDLE;
                            release_r <= 1'b1;
                            long_r    <= 1'b0;
                            cnt       <= '0;
                        end else if (cnt == REPEAT_TC) begin
                            step_r <= 1'b1;
                            cnt    <= '0;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        cnt    <= '0;
                        long_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.press_pulse   = press_r;
    assign bus.release_pulse = release_r;
    assign bus.step_pulse    = step_r;
    assign bus.long_hold     = long_r;

endmodule

// File: tb/tb_btn_press_ctrl.sv
// Directed scoreboard bench for btn_press_ctrl with HOLD_CYCLES=8, REPEAT_CYCLES=4.
module tb_btn_press_ctrl;

    localparam int HOLD = 8;
    localparam int REP  = 4;

    logic cclk;
    logic clr;
    int   checks;
    int   fails;
    logic [3:0] sb[$];

    btn_press_ctrl_if bus();

    btn_press_ctrl #(
        .CNT_W(8),
        .HOLD_CYCLES(HOLD),
        .REPEAT_CYCLES(REP)
    ) dut (
        .cclk(cclk),
        .clr(clr),
        .bus(bus)
    );

    initial cclk = 1'b0;
    always #5 cclk = ~cclk;

    // {press, release, step, long_hold}
    function automatic logic [3:0] outs();
        return {bus.press_pulse, bus.release_pulse, bus.step_pulse, bus.long_hold};
    endfunction

    task automatic compare(input string tag);
        logic [3:0] got;
        logic [3:0] exp;
        got = outs();
        exp = sb.pop_front();
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got p/r/s/l=%b expected %b", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic b, input logic e, input logic [3:0] exp, input string tag);
        bus.btn_in = b;
        bus.en     = e;
        sb.push_back(exp);
        @(posedge cclk);
        #1;
        compare(tag);
    endtask

    // Expected outputs after edge k for a press released at edge rel.
    function automatic logic [3:0] press_exp(int k, int rel);
        logic p, r, s, l;
        p = (k == 0);
        r = (k == rel);
        s = (k < rel) && ((k == 0) || (k >= HOLD && ((k - HOLD) % REP) == 0));
        l = (k >= HOLD) && (k < rel);
        return {p, r, s, l};
    endfunction

    task automatic press_release(input int rel, input string tag);
        for (int k = 0; k <= rel; k++)
            cyc((k < rel), 1'b1, press_exp(k, rel), $sformatf("%s_e%0d", tag, k));
        repeat (2) cyc(1'b0, 1'b1, 4'b0000, {tag, "_after"});
    endtask

    initial begin
        checks     = 0;
        fails      = 0;
        clr        = 1'b1;
        bus.btn_in = 1'b1;
        bus.en     = 1'b1;
        repeat (2) @(posedge cclk);
        #1;
        sb.push_back(4'b0000);
        compare("reset_state");
        clr = 1'b0;

        // Held through reset: never armed.
        for (int i = 0; i < 20; i++) cyc(1'b1, 1'b1, 4'b0000, "held_thru_reset");
        cyc(1'b0, 1'b1, 4'b0000, "arm_low");

        // First press doubles as the short-press case: release at edge 3.
        press_release(3, "short");
        press_release(19, "long");
        press_release(12, "rel_on_tc");

        // en drops at edge 10 during REPEAT and returns at edge 15 with button held.
        for (int k = 0; k < 10; k++)
            cyc(1'b1, 1'b1, press_exp(k, 100), $sformatf("en_pre_e%0d", k));
        for (int k = 10; k < 15; k++) cyc(1'b1, 1'b0, 4'b0000, $sformatf("en_off_e%0d", k));
        for (int k = 15; k < 20; k++) cyc(1'b1, 1'b1, 4'b0000, $sformatf("en_back_e%0d", k));
        cyc(1'b0, 1'b1, 4'b0000, "en_rearm_low");
        cyc(1'b1, 1'b1, 4'b1010, "en_rearm_press");
        cyc(1'b0, 1'b1, 4'b0100, "en_rearm_release");
        cyc(1'b0, 1'b1, 4'b0000, "en_rearm_idle");

        // Asynchronous clr between edges 13 and 14 while in REPEAT.
        for (int k = 0; k <= 13; k++)
            cyc(1'b1, 1'b1, press_exp(k, 100), $sformatf("clr_pre_e%0d", k));
        #3;
        clr = 1'b1;
        #1;
        sb.push_back(4'b0000);
        compare("clr_immediate");
        #1;
        clr = 1'b0;
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1, 4'b0000, "post_clr_held");
        cyc(1'b0, 1'b1, 4'b0000, "post_clr_low");
        cyc(1'b1, 1'b1, 4'b1010, "post_clr_press");
        cyc(1'b1, 1'b1, 4'b0000, "post_clr_hold");
        cyc(1'b0, 1'b1, 4'b0100, "post_clr_release");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
